alu_7seg_scan: RTL and testbench

W-bit registered ALU driving a time-multiplexed bank of W/4 seven-segment digits, one hex nibble per digit. Successor to the single-digit combinational ALU/7-seg pair. Adds:
- parametrised width;
- a load-qualified result register with carry/borrow flag, shown on the decimal point;
- a refresh-counter digit scanner;
- optional leading-zero blanking.

Sits between operand switches/control logic and the board's common-cathode display.

---
 rtl/seg7_pkg.sv | 33 +++
 rtl/alu_core.sv | 29 ++
 rtl/alu_7seg_scan.sv | 93 +++++++++
 tb/tb_alu_7seg_scan.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared opcode encodings and the hex nibble to seven-segment lookup.
package seg7_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_OR  = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

    // Segment order {g,f,e,d,c,b,a}, active-high for a common-cathode display.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h3f;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5b;
            4'h3: s = 7'h4f;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6d;
            4'h6: s = 7'h7d;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7f;
            4'h9: s = 7'h6f;
            4'ha: s = 7'h77;
            4'hb: s = 7'h7c;
            4'hc: s = 7'h39;
            4'hd: s = 7'h5e;
            4'he: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational W-bit ALU; flag is carry-out for add and borrow for sub.
module alu_core
    import seg7_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [1:0]   opcode_i,
    output logic [W-1:0] result_o,
    output logic         flag_o
);

    logic [W:0] wide;

    // The extra top bit of the W+1-bit difference is set exactly when a < b.
    always_comb begin
        wide = '0;
        case (opcode_i)
            OP_ADD:  wide = {1'b0, a_i} + {1'b0, b_i};
            OP_SUB:  wide = {1'b0, a_i} - {1'b0, b_i};
            OP_OR:   wide = {1'b0, a_i | b_i};
            default: wide = {1'b0, a_i ^ b_i};
        endcase
        result_o = wide[W-1:0];
        flag_o   = wide[W];
    end

endmodule

// File: rtl/alu_7seg_scan.sv
// Registered ALU result shown on a scanned bank of W/4 hex digits, carry/borrow on
// digit 0's decimal point, with optional leading-zero blanking.
module alu_7seg_scan
    import seg7_pkg::*;
#(
    parameter int unsigned W       = 8,
    parameter int unsigned REFRESH = 50000,
    parameter int unsigned LZB     = 0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [W-1:0]    a_i,
    input  logic [W-1:0]    b_i,
    input  logic [1:0]      opcode_i,
    input  logic            load_i,
    input  logic            e_i,
    output logic [7:0]      seg_o,
    output logic [W/4-1:0]  an_o
);

    localparam int unsigned DIGITS = W / 4;
    localparam int unsigned CNT_W  = $clog2(REFRESH);
    localparam int unsigned DIG_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [W-1:0]      alu_res;
    logic              alu_flag;
    logic [W-1:0]      res_q, res_d;
    logic              cy_q, cy_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DIG_W-1:0]  dig_q, dig_d;
    logic [7:0]        seg_q, seg_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic [W-1:0]      shifted;
    logic              blank;

    alu_core #(
        .W (W)
    ) u_alu (
        .a_i      (a_i),
        .b_i      (b_i),
        .opcode_i (opcode_i),
        .result_o (alu_res),
        .flag_o   (alu_flag)
    );

    always_comb begin
        res_d = load_i ? alu_res : res_q;
        cy_d  = load_i ? alu_flag : cy_q;

        cnt_d = cnt_q + CNT_W'(1);
        dig_d = dig_q;
        if (cnt_q == CNT_W'(REFRESH - 1)) begin
            cnt_d = '0;
            dig_d = (dig_q == DIG_W'(DIGITS - 1)) ? '0 : dig_q + DIG_W'(1);
        end

        // Bring the selected nibble to the bottom; anything left above it is zero
        // exactly when this digit and all more-significant ones are zero.
        shifted = res_q >> {dig_q, 2'b00};
        blank   = (LZB != 0) && (dig_q != '0) && (shifted == '0);

        seg_d = '0;
        an_d  = '0;
        if (e_i) begin
            an_d = DIGITS'(1) << dig_q;
            if (!blank) begin
                seg_d = {cy_q && (dig_q == '0), hex_to_seg(shifted[3:0])};
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            res_q <= '0;
            cy_q  <= 1'b0;
            cnt_q <= '0;
            dig_q <= '0;
            seg_q <= '0;
            an_q  <= '0;
        end else begin
            res_q <= res_d;
            cy_q  <= cy_d;
            cnt_q <= cnt_d;
            dig_q <= dig_d;
            seg_q <= seg_d;
            an_q  <= an_d;
        end
    end

    assign seg_o = seg_q;
    assign an_o  = an_q;

endmodule

// File: tb/tb_alu_7seg_scan.sv
// Bench for alu_7seg_scan: two instances (blanking off/on) against a time-based model.
module tb_alu_7seg_scan;

    localparam int W       = 8;
    localparam int REFRESH = 4;
    localparam int DIGITS  = W / 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic [1:0] op = '0;
    logic       load = 1'b0;
    logic       e = 1'b0;
    logic [7:0] seg0, seg1;
    logic [1:0] an0, an1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_7seg_scan #(.W(W), .REFRESH(REFRESH), .LZB(0)) dut0 (
        .clk_i(clk), .rst_i(rst), .a_i(a), .b_i(b), .opcode_i(op),
        .load_i(load), .e_i(e), .seg_o(seg0), .an_o(an0)
    );

    alu_7seg_scan #(.W(W), .REFRESH(REFRESH), .LZB(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .a_i(a), .b_i(b), .opcode_i(op),
        .load_i(load), .e_i(e), .seg_o(seg1), .an_o(an1)
    );

    logic [6:0] tbl [16] = '{7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h07,
                            7'h7f, 7'h6f, 7'h77, 7'h7c, 7'h39, 7'h5e, 7'h79, 7'h71};

    // Model: the digit on show at the k-th edge since release is (k-1)/REFRESH mod DIGITS.
    int         m_t;
    logic [7:0] m_res;
    logic       m_cy;
    logic [7:0] x_seg0, x_seg1;
    logic [1:0] x_an;

    always @(posedge clk or posedge rst) begin
        int         d;
        int         s;
        logic [7:0] up;
        if (rst) begin
            m_t <= 0; m_res <= '0; m_cy <= 1'b0;
            x_seg0 <= '0; x_seg1 <= '0; x_an <= '0;
        end else begin
            d  = (m_t / REFRESH) % DIGITS;
            up = m_res >> (4 * d);
            m_t <= m_t + 1;
            if (e) begin
                x_an   <= 2'(1 << d);
                x_seg0 <= {(d == 0) && m_cy, tbl[up[3:0]]};
                x_seg1 <= (d != 0 && up == 0) ? 8'h00 : {(d == 0) && m_cy, tbl[up[3:0]]};
            end else begin
                x_an <= '0; x_seg0 <= '0; x_seg1 <= '0;
            end
            if (load) begin
                case (op)
                    2'd0: begin s = int'(a) + int'(b); m_res <= 8'(s); m_cy <= (s > 255); end
                    2'd1: begin m_res <= a - b; m_cy <= (a < b); end
                    2'd2: begin m_res <= a | b; m_cy <= 1'b0; end
                    default: begin m_res <= a ^ b; m_cy <= 1'b0; end
                endcase
            end
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %02h, expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("model seg lzb0", seg0, x_seg0);
        check("model an lzb0", {6'b0, an0}, {6'b0, x_an});
        check("model seg lzb1", seg1, x_seg1);
        check("model an lzb1", {6'b0, an1}, {6'b0, x_an});
    end

    task automatic show(input string name, input int dig, input logic [7:0] e0,
                        input logic [7:0] e1);
        int n = 0;
        while (an0 !== 2'(1 << dig) && n < 12) begin
            @(negedge clk);
            n++;
        end
        check({name, " digit reached"}, {6'b0, an0}, 8'(1 << dig));
        check({name, " seg lzb0"}, seg0, e0);
        check({name, " seg lzb1"}, seg1, e1);
        check({name, " an lzb1"}, {6'b0, an1}, 8'(1 << dig));
    endtask

    task automatic do_load(input logic [7:0] ta, input logic [7:0] tb, input logic [1:0] top);
        @(negedge clk);
        a = ta; b = tb; op = top; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int n;
        e = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("first edge an", {6'b0, an0}, 8'h01);
        check("first edge seg", seg0, 8'h3f);
        show("reset d1", 1, 8'h3f, 8'h00);

        // Asynchronous reset landing between edges.
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async rst seg", seg0, 8'h00);
        check("async rst an", {6'b0, an0}, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        do_load(8'h3c, 8'h05, 2'b00);
        show("add d0", 0, 8'h06, 8'h06);
        show("add d1", 1, 8'h66, 8'h66);
        // Digit 0 must be held for exactly REFRESH cycles.
        show("hold sync", 0, 8'h06, 8'h06);
        n = 0;
        while (an0 == 2'b01 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("hold cycles", 8'(n), 8'(REFRESH));

        do_load(8'hff, 8'h02, 2'b00);
        show("carry d0", 0, 8'h86, 8'h86);
        show("carry d1", 1, 8'h3f, 8'h00);

        do_load(8'h03, 8'h05, 2'b01);
        show("borrow d0", 0, 8'hf9, 8'hf9);
        show("borrow d1", 1, 8'h71, 8'h71);
        do_load(8'hf0, 8'h0f, 2'b11);
        show("xor d0", 0, 8'h71, 8'h71);

        do_load(8'h05, 8'h00, 2'b10);
        show("lzb d1", 1, 8'h3f, 8'h00);
        show("lzb d0", 0, 8'h6d, 8'h6d);

        @(negedge clk);
        e = 1'b0;
        @(negedge clk);
        check("disable seg", seg0, 8'h00);
        check("disable an", {6'b0, an0}, 8'h00);
        repeat (9) @(negedge clk);
        e = 1'b1;
        a = 8'h99; b = 8'h11; op = 2'b01;
        repeat (10) @(negedge clk);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            a    = 8'($urandom);
            b    = 8'($urandom);
            op   = 2'($urandom);
            load = ($urandom_range(0, 3) == 0);
            e    = ($urandom_range(0, 9) != 0);
            rst  = ($urandom_range(0, 299) == 0);
        end
        @(negedge clk);
        rst = 1'b0; load = 1'b0;
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
